// File: rtl/vend_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// vend_ctrl_param_if
// Bundle of front-panel inputs and dispenser/hopper outputs of the
// parametrised vending controller.
//
// Optional macro: VEND_AUDIT_EN adds the sales_cnt / refund_cnt audit
// counters to the bundle.
//
// Signals
//   coin_a, coin_b, coin_c : debounced coin sensors, high while coin in slot
//   pay, cancel            : purchase / refund buttons, level
//   credit                 : current credit (CREDIT_W bits)
//   payok                  : one-cycle vend pulse
//   change_coin            : one-cycle pulse per smallest coin returned
//   change_busy            : high while vending or returning change
//   reject                 : one-cycle pulse when a coin is refused
//   sales_cnt, refund_cnt  : audit counters (VEND_AUDIT_EN only)
//
// Modports
//   master : front panel / test side, drives buttons and sensors
//   slave  : controller side, drives credit and the pulse outputs
// ---------------------------------------------------------------------------
interface vend_ctrl_param_if #(
  parameter int CREDIT_W = 7
) ();

  logic                coin_a;
  logic                coin_b;
  logic                coin_c;
  logic                pay;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                payok;
  logic                change_coin;
  logic                change_busy;
  logic                reject;

`ifdef VEND_AUDIT_EN
  logic [15:0]         sales_cnt;
  logic [15:0]         refund_cnt;

  modport master (
    output coin_a, coin_b, coin_c, pay, cancel,
    input  credit, payok, change_coin, change_busy, reject,
    input  sales_cnt, refund_cnt
  );

  modport slave (
    input  coin_a, coin_b, coin_c, pay, cancel,
    output credit, payok, change_coin, change_busy, reject,
    output sales_cnt, refund_cnt
  );
`else
  modport master (
    output coin_a, coin_b, coin_c, pay, cancel,
    input  credit, payok, change_coin, change_busy, reject
  );

  modport slave (
    input  coin_a, coin_b, coin_c, pay, cancel,
    output credit, payok, change_coin, change_busy, reject
  );
`endif

endinterface

// File: rtl/vend_ctrl_param.sv
// ---------------------------------------------------------------------------
// vend_ctrl_param
// Parametrised coin-operated vending controller. Accepts three coin
// denominations up to a credit ceiling, vends at a fixed price, and returns
// change (or a full refund on cancel) one smallest coin at a time, with a
// low cycle between change pulses so the hopper driver can keep up.
//
// Optional macro: VEND_AUDIT_EN adds saturating 16-bit sales and refund
// counters (bus.sales_cnt, bus.refund_cnt). Without it those counters do
// not exist and the behaviour is otherwise identical.
//
// Ports
//   ck    : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : vend_ctrl_param_if.slave
//           inputs  coin_a, coin_b, coin_c, pay, cancel (level)
//           outputs credit, payok, change_coin, change_busy, reject
//                   (+ sales_cnt, refund_cnt with VEND_AUDIT_EN)
// ---------------------------------------------------------------------------
module vend_ctrl_param #(
  parameter int CREDIT_W   = 7,
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 60,
  parameter int COIN_A     = 5,
  parameter int COIN_B     = 10,
  parameter int COIN_C     = 50
) (
  input logic               ck,
  input logic               reset,
  vend_ctrl_param_if.slave  bus
);

  // One extra bit of headroom so credit + coin can be compared against the
  // ceiling without wrapping.
  localparam int CW1 = CREDIT_W + 1;

  localparam logic [CREDIT_W:0]   MAX_X   = CW1'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   VAL_A_X = CW1'(COIN_A);
  localparam logic [CREDIT_W:0]   VAL_B_X = CW1'(COIN_B);
  localparam logic [CREDIT_W:0]   VAL_C_X = CW1'(COIN_C);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(COIN_A);

  typedef enum logic [1:0] {
    IDLE,
    VEND,
    CHG_LO,
    CHG_HI
  } state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic                payok_q;
  logic                change_coin_q;
  logic                reject_q;

`ifdef VEND_AUDIT_EN
  logic [15:0]         sales_q;
  logic [15:0]         refund_q;
  // Set when the current change run was started by cancel, so that only
  // refunds (not change after a sale) are audited.
  logic                refund_run;
`endif

  // Input history, bit order {cancel, pay, coin_c, coin_b, coin_a}.
  logic [4:0] in_now;
  logic [4:0] in_samp;
  logic [4:0] in_prev;
  logic [4:0] rel;

  assign in_now = {bus.cancel, bus.pay, bus.coin_c, bus.coin_b, bus.coin_a};

  // Two-deep sample history per input; a release is seen when the older
  // sample is high and the newer one low.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      in_samp <= '0;
      in_prev <= '0;
    end else begin
      in_samp <= in_now;
      in_prev <= in_samp;
    end
  end

  logic                rel_cancel;
  logic                rel_pay;
  logic                any_coin;
  logic                multi_coin;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit_upd;

  // Coin evaluation for the IDLE state. credit_upd is the credit after the
  // coin (if accepted), and pay/cancel are judged against it in the same
  // cycle. Two or more simultaneous coins are refused as a group.
  always_comb begin
    rel        = in_prev & ~in_samp;
    rel_cancel = rel[4];
    rel_pay    = rel[3];
    any_coin   = |rel[2:0];
    multi_coin = (rel[0] & rel[1]) | (rel[0] & rel[2]) | (rel[1] & rel[2]);

    coin_val = '0;
    if (rel[0]) begin
      coin_val = VAL_A_X;
    end else if (rel[1]) begin
      coin_val = VAL_B_X;
    end else if (rel[2]) begin
      coin_val = VAL_C_X;
    end

    coin_sum    = {1'b0, credit_q} + coin_val;
    coin_ok     = any_coin && !multi_coin && (coin_sum <= MAX_X);
    coin_reject = any_coin && !coin_ok;
    credit_upd  = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
  end

  // Main controller. The pulse outputs default low every cycle so each one
  // is exactly one cycle wide. Outside IDLE any coin is bounced and
  // pay/cancel releases are dropped.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      credit_q      <= '0;
      payok_q       <= 1'b0;
      change_coin_q <= 1'b0;
      reject_q      <= 1'b0;
`ifdef VEND_AUDIT_EN
      sales_q       <= '0;
      refund_q      <= '0;
      refund_run    <= 1'b0;
`endif
    end else begin
      payok_q       <= 1'b0;
      change_coin_q <= 1'b0;
      reject_q      <= 1'b0;

      case (state)
        IDLE: begin
          reject_q <= coin_reject;
          credit_q <= credit_upd;
          if (rel_cancel && (credit_upd != '0)) begin
            state <= CHG_LO;
`ifdef VEND_AUDIT_EN
            refund_run <= 1'b1;
`endif
          end else if (rel_pay && (credit_upd >= PRICE_C)) begin
            credit_q <= credit_upd - PRICE_C;
            payok_q  <= 1'b1;
            state    <= VEND;
`ifdef VEND_AUDIT_EN
            refund_run <= 1'b0;
            if (sales_q != 16'hFFFF) begin
              sales_q <= sales_q + 16'd1;
            end
`endif
          end
        end

        VEND: begin
          reject_q <= any_coin;
          state    <= (credit_q == '0) ? IDLE : CHG_LO;
        end

        CHG_LO: begin
          reject_q <= any_coin;
          if (credit_q == '0) begin
            state <= IDLE;
          end else begin
            credit_q      <= credit_q - UNIT_C;
            change_coin_q <= 1'b1;
            state         <= CHG_HI;
`ifdef VEND_AUDIT_EN
            if (refund_run && (refund_q != 16'hFFFF)) begin
              refund_q <= refund_q + 16'd1;
            end
`endif
          end
        end

        CHG_HI: begin
          reject_q <= any_coin;
          state    <= CHG_LO;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.credit      = credit_q;
  assign bus.payok       = payok_q;
  assign bus.change_coin = change_coin_q;
  assign bus.reject      = reject_q;
  assign bus.change_busy = (state != IDLE);

`ifdef VEND_AUDIT_EN
  assign bus.sales_cnt   = sales_q;
  assign bus.refund_cnt  = refund_q;
`endif

endmodule

// File: tb/tb_vend_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl_param
// Self-checking bench for vend_ctrl_param. Each front-panel action is a
// "transaction" (raise a set of inputs, release them together); the
// expected credit and pulse counts come from an arithmetic model of the
// vending rules. A monitor counts output pulses and records credit at
// every change pulse.
// ---------------------------------------------------------------------------
module tb_vend_ctrl_param;

  localparam int CREDIT_W   = 7;
  localparam int PRICE      = 25;
  localparam int MAX_CREDIT = 60;
  localparam int COIN_A     = 5;
  localparam int COIN_B     = 10;
  localparam int COIN_C     = 50;

  // Transaction masks, bit order {cancel, pay, coin_c, coin_b, coin_a}.
  localparam logic [4:0] M_A      = 5'b00001;
  localparam logic [4:0] M_B      = 5'b00010;
  localparam logic [4:0] M_C      = 5'b00100;
  localparam logic [4:0] M_PAY    = 5'b01000;
  localparam logic [4:0] M_CANCEL = 5'b10000;

  logic ck    = 1'b0;
  logic reset = 1'b0;

  vend_ctrl_param_if #(.CREDIT_W(CREDIT_W)) bus ();

  vend_ctrl_param #(
    .CREDIT_W   (CREDIT_W),
    .PRICE      (PRICE),
    .MAX_CREDIT (MAX_CREDIT),
    .COIN_A     (COIN_A),
    .COIN_B     (COIN_B),
    .COIN_C     (COIN_C)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_pass   = 0;

  int timeout_cnt = 0;
  int pay_pulses  = 0;
  int chg_pulses  = 0;
  int rej_pulses  = 0;
  int width_errs  = 0;
  int chg_credits[$];
  logic prev_payok = 1'b0;
  logic prev_chg   = 1'b0;
  logic prev_rej   = 1'b0;

  int model_credit = 0;
`ifdef VEND_AUDIT_EN
  int model_sales  = 0;
  int model_refund = 0;
`endif

  // Pulse monitor: counts pulses, notes any pulse lasting two samples, and
  // records credit whenever a change coin is being paid out.
  always @(negedge ck) begin
    if (!reset) begin
      prev_payok = 1'b0;
      prev_chg   = 1'b0;
      prev_rej   = 1'b0;
    end else begin
      if (bus.payok === 1'b1) begin
        pay_pulses++;
        if (prev_payok) width_errs++;
      end
      if (bus.change_coin === 1'b1) begin
        chg_pulses++;
        chg_credits.push_back(int'(bus.credit));
        if (prev_chg) width_errs++;
      end
      if (bus.reject === 1'b1) begin
        rej_pulses++;
        if (prev_rej) width_errs++;
      end
      prev_payok = (bus.payok === 1'b1);
      prev_chg   = (bus.change_coin === 1'b1);
      prev_rej   = (bus.reject === 1'b1);
    end
  end

  // Vending rules at transaction level: one coin is added if it fits under
  // the ceiling, otherwise (or if several coins) one reject; then cancel
  // returns everything, else pay buys and returns the remainder as coins.
  function automatic void model_txn(input logic [4:0] m,
                                    output int e_pay, output int e_chg,
                                    output int e_rej);
    int ncoin;
    int v;
    e_pay = 0;
    e_chg = 0;
    e_rej = 0;
    ncoin = int'(m[0]) + int'(m[1]) + int'(m[2]);
    if (ncoin == 1) begin
      v = m[0] ? COIN_A : (m[1] ? COIN_B : COIN_C);
      if (model_credit + v <= MAX_CREDIT) model_credit += v;
      else e_rej = 1;
    end else if (ncoin > 1) begin
      e_rej = 1;
    end
    if (m[4] && model_credit > 0) begin
      e_chg = model_credit / COIN_A;
      model_credit = 0;
`ifdef VEND_AUDIT_EN
      model_refund += e_chg;
`endif
    end else if (m[3] && model_credit >= PRICE) begin
      e_pay = 1;
      model_credit -= PRICE;
      e_chg = model_credit / COIN_A;
      model_credit = 0;
`ifdef VEND_AUDIT_EN
      model_sales++;
`endif
    end
  endfunction

  // Raise the selected inputs, release them together, then let the
  // controller finish any vend/change sequence (bounded wait).
  task automatic applyStimulus(input logic [4:0] m);
    int k;
    @(negedge ck);
    {bus.cancel, bus.pay, bus.coin_c, bus.coin_b, bus.coin_a} = m;
    repeat (2) @(negedge ck);
    {bus.cancel, bus.pay, bus.coin_c, bus.coin_b, bus.coin_a} = 5'b0;
    repeat (3) @(negedge ck);
    k = 0;
    while (bus.change_busy !== 1'b0 && k < 60) begin
      @(negedge ck);
      k++;
    end
    if (bus.change_busy !== 1'b0) timeout_cnt++;
    repeat (2) @(negedge ck);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge ck);
    n_checks++;
    if (bus.credit !== 7'd0) $display("[TB] FAIL reset_credit got %0d want 0", bus.credit);
    else n_pass++;
    n_checks++;
    if ({bus.payok, bus.change_coin, bus.reject, bus.change_busy} !== 4'b0)
      $display("[TB] FAIL reset_pulses got %b want 0000",
               {bus.payok, bus.change_coin, bus.reject, bus.change_busy});
    else n_pass++;
`ifdef VEND_AUDIT_EN
    n_checks++;
    if (bus.sales_cnt !== 16'd0 || bus.refund_cnt !== 16'd0)
      $display("[TB] FAIL reset_audit got %0d/%0d want 0/0", bus.sales_cnt, bus.refund_cnt);
    else n_pass++;
`endif
    @(negedge ck);
    reset = 1'b1;
    model_credit = 0;
    repeat (2) @(negedge ck);
  endtask

  task automatic test_exact_pay;
    logic [4:0] seq [3];
    int want [3];
    int ep, ec, er, p0, c0;
    seq = '{M_B, M_B, M_A};
    want = '{10, 20, 25};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(seq[i]);
      model_txn(seq[i], ep, ec, er);
      n_checks++;
      if (bus.credit !== CREDIT_W'(want[i]))
        $display("[TB] FAIL exact_credit%0d got %0d want %0d", i, bus.credit, want[i]);
      else n_pass++;
    end
    p0 = pay_pulses;
    c0 = chg_pulses;
    applyStimulus(M_PAY);
    model_txn(M_PAY, ep, ec, er);
    n_checks++;
    if (pay_pulses - p0 !== 1) $display("[TB] FAIL exact_payok got %0d want 1", pay_pulses - p0);
    else n_pass++;
    n_checks++;
    if (chg_pulses - c0 !== 0) $display("[TB] FAIL exact_change got %0d want 0", chg_pulses - c0);
    else n_pass++;
    n_checks++;
    if (bus.credit !== 7'd0 || bus.change_busy !== 1'b0)
      $display("[TB] FAIL exact_final got credit %0d busy %b want 0 0", bus.credit, bus.change_busy);
    else n_pass++;
  endtask

  task automatic test_change;
    int ep, ec, er, p0, c0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(M_B);
      model_txn(M_B, ep, ec, er);
    end
    n_checks++;
    if (bus.credit !== 7'd30) $display("[TB] FAIL change_credit got %0d want 30", bus.credit);
    else n_pass++;
    p0 = pay_pulses;
    c0 = chg_pulses;
    applyStimulus(M_PAY);
    model_txn(M_PAY, ep, ec, er);
    n_checks++;
    if (pay_pulses - p0 !== 1 || chg_pulses - c0 !== 1)
      $display("[TB] FAIL change_pulses got pay %0d chg %0d want 1 1", pay_pulses - p0, chg_pulses - c0);
    else n_pass++;
    n_checks++;
    if (bus.credit !== 7'd0 || bus.change_busy !== 1'b0)
      $display("[TB] FAIL change_final got credit %0d busy %b want 0 0", bus.credit, bus.change_busy);
    else n_pass++;
  endtask

  task automatic test_cancel;
    int ep, ec, er, c0;
    bit seq_ok;
    applyStimulus(M_C);
    model_txn(M_C, ep, ec, er);
    n_checks++;
    if (bus.credit !== 7'd50) $display("[TB] FAIL cancel_credit got %0d want 50", bus.credit);
    else n_pass++;
    chg_credits.delete();
    c0 = chg_pulses;
    applyStimulus(M_CANCEL);
    model_txn(M_CANCEL, ep, ec, er);
    n_checks++;
    if (chg_pulses - c0 !== 10) $display("[TB] FAIL cancel_count got %0d want 10", chg_pulses - c0);
    else n_pass++;
    seq_ok = (chg_credits.size() == 10);
    for (int i = 0; i < chg_credits.size() && i < 10; i++)
      if (chg_credits[i] != 45 - 5 * i) seq_ok = 0;
    n_checks++;
    if (!seq_ok) $display("[TB] FAIL cancel_steps got %p want 45..0 step 5", chg_credits);
    else n_pass++;
    n_checks++;
    if (bus.credit !== 7'd0 || width_errs !== 0)
      $display("[TB] FAIL cancel_final got credit %0d widerr %0d want 0 0", bus.credit, width_errs);
    else n_pass++;
  endtask

  task automatic test_overflow;
    int ep, ec, er, r0;
    applyStimulus(M_C);
    model_txn(M_C, ep, ec, er);
    applyStimulus(M_B);
    model_txn(M_B, ep, ec, er);
    n_checks++;
    if (bus.credit !== 7'd60) $display("[TB] FAIL ovf_fill got %0d want 60", bus.credit);
    else n_pass++;
    r0 = rej_pulses;
    applyStimulus(M_A);
    model_txn(M_A, ep, ec, er);
    n_checks++;
    if (rej_pulses - r0 !== 1 || bus.credit !== 7'd60)
      $display("[TB] FAIL ovf_single got rej %0d credit %0d want 1 60", rej_pulses - r0, bus.credit);
    else n_pass++;
    r0 = rej_pulses;
    applyStimulus(M_A | M_B);
    model_txn(M_A | M_B, ep, ec, er);
    n_checks++;
    if (rej_pulses - r0 !== 1 || bus.credit !== 7'd60)
      $display("[TB] FAIL ovf_double got rej %0d credit %0d want 1 60", rej_pulses - r0, bus.credit);
    else n_pass++;
    applyStimulus(M_CANCEL);
    model_txn(M_CANCEL, ep, ec, er);
    n_checks++;
    if (bus.credit !== 7'd0) $display("[TB] FAIL ovf_clear got %0d want 0", bus.credit);
    else n_pass++;
  endtask

  task automatic test_busy_reject;
    int ep, ec, er, p0, c0, r0, k;
    bit seq_ok;
    applyStimulus(M_B);
    model_txn(M_B, ep, ec, er);
    applyStimulus(M_B);
    model_txn(M_B, ep, ec, er);
    p0 = pay_pulses;
    applyStimulus(M_PAY);
    model_txn(M_PAY, ep, ec, er);
    n_checks++;
    if (pay_pulses - p0 !== 0 || bus.credit !== 7'd20)
      $display("[TB] FAIL insuff got pay %0d credit %0d want 0 20", pay_pulses - p0, bus.credit);
    else n_pass++;
    // Cancel, and drop coin_b while the refund is still running.
    chg_credits.delete();
    c0 = chg_pulses;
    r0 = rej_pulses;
    @(negedge ck);
    bus.cancel = 1'b1;
    repeat (2) @(negedge ck);
    bus.cancel = 1'b0;
    bus.coin_b = 1'b1;
    repeat (2) @(negedge ck);
    bus.coin_b = 1'b0;
    k = 0;
    while (bus.change_busy !== 1'b0 && k < 60) begin
      @(negedge ck);
      k++;
    end
    if (bus.change_busy !== 1'b0) timeout_cnt++;
    repeat (3) @(negedge ck);
    model_credit = 0;
`ifdef VEND_AUDIT_EN
    model_refund += 4;
`endif
    n_checks++;
    if (rej_pulses - r0 !== 1) $display("[TB] FAIL busy_reject got %0d want 1", rej_pulses - r0);
    else n_pass++;
    seq_ok = (chg_credits.size() == 4);
    for (int i = 0; i < chg_credits.size() && i < 4; i++)
      if (chg_credits[i] != 15 - 5 * i) seq_ok = 0;
    n_checks++;
    if (!seq_ok || chg_pulses - c0 !== 4)
      $display("[TB] FAIL busy_steps got %p want 15,10,5,0", chg_credits);
    else n_pass++;
    n_checks++;
    if (bus.credit !== 7'd0) $display("[TB] FAIL busy_final got %0d want 0", bus.credit);
    else n_pass++;
  endtask

  task automatic test_simultaneous;
    logic [4:0] seq [6];
    int ep, ec, er, p0, c0;
    seq = '{M_B, M_B, M_B, M_PAY | M_CANCEL, M_C, M_A | M_PAY};
    // 30 then pay+cancel -> refund 6; 50 then coin_a+pay -> 55, vend, 6 back.
    for (int i = 0; i < 6; i++) begin
      p0 = pay_pulses;
      c0 = chg_pulses;
      applyStimulus(seq[i]);
      model_txn(seq[i], ep, ec, er);
      n_checks++;
      if (bus.credit !== CREDIT_W'(model_credit) || pay_pulses - p0 !== ep || chg_pulses - c0 !== ec)
        $display("[TB] FAIL simul%0d got credit %0d pay %0d chg %0d want %0d %0d %0d",
                 i, bus.credit, pay_pulses - p0, chg_pulses - c0, model_credit, ep, ec);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [4:0] m;
      int ep, ec, er, p0, c0, r0;
      m[0] = ($urandom_range(0, 99) < 40);
      m[1] = ($urandom_range(0, 99) < 40);
      m[2] = ($urandom_range(0, 99) < 25);
      m[3] = ($urandom_range(0, 99) < 25);
      m[4] = ($urandom_range(0, 99) < 12);
      p0 = pay_pulses;
      c0 = chg_pulses;
      r0 = rej_pulses;
      applyStimulus(m);
      model_txn(m, ep, ec, er);
      n_checks++;
      if (bus.credit !== CREDIT_W'(model_credit))
        $display("[TB] FAIL rnd%0d_credit m=%b got %0d want %0d", i, m, bus.credit, model_credit);
      else n_pass++;
      n_checks++;
      if (pay_pulses - p0 !== ep)
        $display("[TB] FAIL rnd%0d_payok m=%b got %0d want %0d", i, m, pay_pulses - p0, ep);
      else n_pass++;
      n_checks++;
      if (chg_pulses - c0 !== ec)
        $display("[TB] FAIL rnd%0d_change m=%b got %0d want %0d", i, m, chg_pulses - c0, ec);
      else n_pass++;
      n_checks++;
      if (rej_pulses - r0 !== er)
        $display("[TB] FAIL rnd%0d_reject m=%b got %0d want %0d", i, m, rej_pulses - r0, er);
      else n_pass++;
    end
    n_checks++;
    if (width_errs !== 0 || timeout_cnt !== 0)
      $display("[TB] FAIL pulse_health got widerr %0d timeouts %0d want 0 0", width_errs, timeout_cnt);
    else n_pass++;
  endtask

`ifdef VEND_AUDIT_EN
  task automatic test_audit;
    n_checks++;
    if (bus.sales_cnt !== 16'(model_sales))
      $display("[TB] FAIL audit_sales got %0d want %0d", bus.sales_cnt, model_sales);
    else n_pass++;
    n_checks++;
    if (bus.refund_cnt !== 16'(model_refund))
      $display("[TB] FAIL audit_refund got %0d want %0d", bus.refund_cnt, model_refund);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid;
    int ep, ec, er, k;
    applyStimulus(M_CANCEL);
    model_txn(M_CANCEL, ep, ec, er);
    applyStimulus(M_C);
    model_txn(M_C, ep, ec, er);
    n_checks++;
    if (bus.credit !== 7'd50) $display("[TB] FAIL rstmid_fill got %0d want 50", bus.credit);
    else n_pass++;
    @(negedge ck);
    bus.cancel = 1'b1;
    repeat (2) @(negedge ck);
    bus.cancel = 1'b0;
    k = 0;
    while (bus.change_coin !== 1'b1 && k < 20) begin
      @(negedge ck);
      k++;
    end
    n_checks++;
    if (bus.change_coin !== 1'b1) $display("[TB] FAIL rstmid_reach got change_coin %b want 1", bus.change_coin);
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.credit !== 7'd0 ||
        {bus.payok, bus.change_coin, bus.reject, bus.change_busy} !== 4'b0)
      $display("[TB] FAIL rstmid_async got credit %0d flags %b want 0 0000", bus.credit,
               {bus.payok, bus.change_coin, bus.reject, bus.change_busy});
    else n_pass++;
    @(negedge ck);
    reset = 1'b1;
    model_credit = 0;
    repeat (4) @(negedge ck);
    n_checks++;
    if (bus.credit !== 7'd0 || bus.change_busy !== 1'b0)
      $display("[TB] FAIL rstmid_after got credit %0d busy %b want 0 0", bus.credit, bus.change_busy);
    else n_pass++;
`ifdef VEND_AUDIT_EN
    n_checks++;
    if (bus.sales_cnt !== 16'd0 || bus.refund_cnt !== 16'd0)
      $display("[TB] FAIL rstmid_audit got %0d/%0d want 0/0", bus.sales_cnt, bus.refund_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    {bus.cancel, bus.pay, bus.coin_c, bus.coin_b, bus.coin_a} = 5'b0;
    test_reset();
    test_exact_pay();
    test_change();
    test_cancel();
    test_overflow();
    test_busy_reject();
    test_simultaneous();
    test_random();
`ifdef VEND_AUDIT_EN
    test_audit();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
